// File: rtl/ir_err_calc.sv
// IR line-error calculator: weighted multiply-accumulate over one
// snapshot of eight IR readings, then scale, saturate and track line loss.
module ir_err_calc #(
  parameter int SHIFT     = 4,
  parameter int LOST_RNDS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_vld,
  input  logic        line_present,
  input  logic [11:0] IR_R0,
  input  logic [11:0] IR_R1,
  input  logic [11:0] IR_R2,
  input  logic [11:0] IR_R3,
  input  logic [11:0] IR_L0,
  input  logic [11:0] IR_L1,
  input  logic [11:0] IR_L2,
  input  logic [11:0] IR_L3,
  output logic [11:0] err,
  output logic        err_vld,
  output logic        line_lost,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [3:0] LOST_MAX = 4'(LOST_RNDS);
  localparam logic signed [17:0] ERR_MAX = 18'sd2047;
  localparam logic signed [17:0] ERR_MIN = -18'sd2048;

  state_t state;
  state_t state_nxt;

  logic [11:0] snap_r [4];
  logic [11:0] snap_l [4];
  logic        snap_lp;

  logic signed [17:0] acc;
  logic [2:0]         idx;
  logic [3:0]         lost_cnt;

  logic take;
  logic acc_en;
  logic finish;
  logic busy_hit;

  logic [11:0]        sel;
  logic signed [17:0] mag;
  logic signed [17:0] scaled;
  logic [11:0]        err_sat;
  logic [3:0]         lost_nxt;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (IR_vld) state_nxt = ACC;
      ACC:  if (idx == 3'd7) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control decode
  always_comb begin
    take     = 1'b0;
    acc_en   = 1'b0;
    finish   = 1'b0;
    busy_hit = 1'b0;
    unique case (1'b1)
      (state == IDLE): take = IR_vld;
      (state == ACC): begin
        acc_en   = 1'b1;
        busy_hit = IR_vld;
      end
      (state == DONE): begin
        finish   = 1'b1;
        busy_hit = IR_vld;
      end
      default: ;
    endcase
  end

  // snapshot is written only on an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        snap_r[k] <= '0;
        snap_l[k] <= '0;
      end
      snap_lp <= 1'b0;
    end else if (take) begin
      snap_r[0] <= IR_R0;
      snap_r[1] <= IR_R1;
      snap_r[2] <= IR_R2;
      snap_r[3] <= IR_R3;
      snap_l[0] <= IR_L0;
      snap_l[1] <= IR_L1;
      snap_l[2] <= IR_L2;
      snap_l[3] <= IR_L3;
      snap_lp   <= line_present;
    end
  end

  // idx[2] picks the side, idx[1:0] is both sensor and shift
  always_comb begin
    sel = idx[2] ? snap_l[idx[1:0]] : snap_r[idx[1:0]];
    mag = $signed({6'b0, sel} << idx[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (take) begin
      acc <= '0;
      idx <= '0;
    end else if (acc_en) begin
      acc <= idx[2] ? acc - mag : acc + mag;
      idx <= idx + 3'd1;
    end
  end

  always_comb begin
    scaled = acc >>> SHIFT;
    if (scaled > ERR_MAX) begin
      err_sat = 12'h7FF;
    end else if (scaled < ERR_MIN) begin
      err_sat = 12'h800;
    end else begin
      err_sat = scaled[11:0];
    end
  end

  always_comb begin
    if (snap_lp) begin
      lost_nxt = '0;
    end else if (lost_cnt == LOST_MAX) begin
      lost_nxt = LOST_MAX;
    end else begin
      lost_nxt = lost_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= '0;
      err_vld   <= 1'b0;
      line_lost <= 1'b0;
      lost_cnt  <= '0;
    end else begin
      err_vld <= finish;
      if (finish) begin
        if (snap_lp) err <= err_sat;
        lost_cnt  <= lost_nxt;
        line_lost <= (lost_nxt == LOST_MAX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (busy_hit) begin
      overrun <= 1'b1;
    end
  end

endmodule
